// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and stream framing constants for imem_loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam int HEADER_BYTES   = 1;
    localparam int BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - assembles little-endian bytes into 32-bit words with a one-cycle word_valid
module byte_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0] byte_cnt;

    assign last_byte = (byte_cnt == LAST_BYTE_IDX);

    // Shifting in from the top leaves the first byte in bits 7:0 after four bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt   <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= byte_en && last_byte;
            if (clear) begin
                byte_cnt <= '0;
            end else if (byte_en) begin
                byte_cnt <= byte_cnt + 2'd1;
                word     <= {byte_data, word[31:8]};
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction memory loader; optional trailer checksum via IMEM_LOADER_CHECKSUM_EN
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam logic [7:0] DEPTH_B = 8'(DEPTH_WORDS);

    state_t     state, state_nxt;
    logic [7:0] n_words;
    logic [7:0] word_cnt;
    logic       last_byte;
    logic       pay_en;
    logic       last_word;

    assign pay_en    = byte_valid && (state == ST_PAYLOAD);
    assign last_word = last_byte && (word_cnt == n_words - 8'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
`endif

    byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (state == ST_HEADER),
        .byte_en    (pay_en),
        .byte_data  (byte_data),
        .last_byte  (last_byte),
        .word_valid (imem_we),
        .word       (imem_wdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_reset  = 1'b1;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_HEADER;
            end
            ST_HEADER: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    if (byte_data == 8'd0 || byte_data > DEPTH_B) state_nxt = ST_ERROR;
                    else                                          state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                byte_ready = 1'b1;
                if (byte_valid && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_nxt = ST_CHECK;
`else
                    state_nxt = ST_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                byte_ready = 1'b1;
                if (byte_valid) state_nxt = (byte_data == csum) ? ST_DONE : ST_ERROR;
            end
`endif
            ST_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
                if (start) state_nxt = ST_HEADER;
            end
            ST_ERROR: begin
                error = 1'b1;
                if (start) state_nxt = ST_HEADER;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The write address is captured with the 4th byte so it lines up with the packer's word_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_words   <= '0;
            word_cnt  <= '0;
            imem_addr <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            if (state == ST_HEADER && byte_valid) begin
                n_words  <= byte_data;
                word_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end
            if (pay_en) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum <= csum ^ byte_data;
`endif
                if (last_byte) begin
                    imem_addr <= word_cnt[ADDR_W-1:0];
                    word_cnt  <= word_cnt + 8'd1;
                end
            end
        end
    end

endmodule
